// File: rtl/program_counter_stack.sv
// Program counter with a hardware return-address stack for call/ret.
// Optional PC-relative jumps are enabled by defining PC_REL_EN.
module program_counter_stack #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 4,
    parameter int STEP       = 1,
    parameter int RESET_ADDR = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       up,
    input  logic                       jump,
    input  logic                       rel,
    input  logic                       call,
    input  logic                       ret,
    input  logic [WIDTH-1:0]           in,
    output logic [WIDTH-1:0]           PC_next,
    output logic [$clog2(DEPTH+1)-1:0] sp,
    output logic                       full,
    output logic                       empty,
    output logic                       err
);

    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_ADDR);
    localparam logic [SP_W-1:0]  DEPTH_W = SP_W'(DEPTH);

    logic [WIDTH-1:0] pc_reg,  pc_next;
    logic [SP_W-1:0]  sp_reg,  sp_next;
    logic             err_reg, err_next;
    logic             push;
    logic             full_w;
    logic             empty_w;
    logic [IDX_W-1:0] push_idx;
    logic [IDX_W-1:0] top_idx;
    logic [WIDTH-1:0] ret_addr;

    logic [WIDTH-1:0] stack_mem [DEPTH];

`ifndef PC_REL_EN
    // rel is kept on the port list so both builds instantiate identically.
    logic unused_rel;
    assign unused_rel = rel;
`endif

    assign full_w   = (sp_reg == DEPTH_W);
    assign empty_w  = (sp_reg == '0);
    assign push_idx = IDX_W'(sp_reg);
    assign top_idx  = IDX_W'(sp_reg - 1'b1);
    assign ret_addr = stack_mem[top_idx];

    // Fixed priority: jump > call > ret > up > hold (rst handled in the register).
    always_comb begin
        pc_next  = pc_reg;
        sp_next  = sp_reg;
        err_next = err_reg;
        push     = 1'b0;
        if (jump) begin
`ifdef PC_REL_EN
            if (rel) begin
                // Same-width add is equivalent to adding the sign-extended offset.
                pc_next = pc_reg + in;
            end else begin
                pc_next = in;
            end
`else
            pc_next = in;
`endif
        end else if (call) begin
            if (full_w) begin
                err_next = 1'b1;
            end else begin
                push    = 1'b1;
                sp_next = sp_reg + 1'b1;
                pc_next = in;
            end
        end else if (ret) begin
            if (empty_w) begin
                err_next = 1'b1;
            end else begin
                sp_next = sp_reg - 1'b1;
                pc_next = ret_addr;
            end
        end else if (up) begin
            pc_next = pc_reg + STEP_W;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg  <= RESET_W;
            sp_reg  <= '0;
            err_reg <= 1'b0;
        end else begin
            pc_reg  <= pc_next;
            sp_reg  <= sp_next;
            err_reg <= err_next;
        end
    end

    // Stack contents are not reset; entries above sp are don't-care.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            stack_mem[push_idx] <= pc_reg + STEP_W;
        end
    end

    assign PC_next = pc_reg;
    assign sp      = sp_reg;
    assign full    = full_w;
    assign empty   = empty_w;
    assign err     = err_reg;

endmodule
